// File: rtl/pipe_ctrl_if.sv
// Control bundle between the decode stage of the core and the pipeline sequencer.
// The core side drives the decoded-instruction view; the sequencer returns enables and forward selects.
interface pipe_ctrl_if #(
    parameter int CNTW = 16
);
    logic            id_valid;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic [4:0]      id_rd;
    logic            id_wb;
    logic            id_load;
    logic            id_fence;
    logic            ex_redirect;
    logic            mem_busy;

    logic            if_en;
    logic            id_en;
    logic            bubble;
    logic            flush;
    logic [1:0]      fwd_rs1;
    logic [1:0]      fwd_rs2;
    logic [1:0]      ctrl_state;
    logic [CNTW-1:0] stall_cycles;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wb, id_load,
               id_fence, ex_redirect, mem_busy,
        input  if_en, id_en, bubble, flush, fwd_rs1, fwd_rs2, ctrl_state, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wb, id_load,
               id_fence, ex_redirect, mem_busy,
        output if_en, id_en, bubble, flush, fwd_rs1, fwd_rs2, ctrl_state, stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the IF/ID/EX/MEM/WB core: hazard stalls, operand forwarding,
// redirect flushes, FENCE drain and memory-stall freeze.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNTW         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN     = 2'b00,
        LDSTALL = 2'b01,
        FLUSH   = 2'b10,
        DRAIN   = 2'b11
    } state_t;

    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_MEM    = 2'b01;
    localparam logic [1:0] FWD_WB     = 2'b10;
    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

    state_t          state, state_nxt;
    logic [1:0]      flush_cnt, flush_cnt_nxt;
    logic            vld_p0, vld_p1, vld_p2;
    logic [4:0]      rd_p0, rd_p1;
    logic            wb_p0, wb_p1, ld_p0;
    logic [1:0]      fwd1_q, fwd2_q, fwd1_d, fwd2_d;
    logic [CNTW-1:0] stall_cnt;
    logic            if_en_c, id_en_c, bubble_c, flush_c;
    logic            ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    logic            load_use, slots_empty, enter_ex;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // x0 is hardwired zero, so it never creates a dependency
    function automatic logic hit(input logic use_rs, input logic [4:0] rs,
                                 input logic vld, input logic wb, input logic [4:0] rd);
        return use_rs && (rs != 5'd0) && vld && wb && (rd == rs);
    endfunction

    assign ex_hit1     = hit(bus.id_use_rs1, bus.id_rs1, vld_p0, wb_p0, rd_p0);
    assign ex_hit2     = hit(bus.id_use_rs2, bus.id_rs2, vld_p0, wb_p0, rd_p0);
    assign mem_hit1    = hit(bus.id_use_rs1, bus.id_rs1, vld_p1, wb_p1, rd_p1);
    assign mem_hit2    = hit(bus.id_use_rs2, bus.id_rs2, vld_p1, wb_p1, rd_p1);
    assign load_use    = bus.id_valid && ld_p0 && (ex_hit1 || ex_hit2);
    assign slots_empty = !(vld_p0 || vld_p1 || vld_p2);

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        if_en_c       = 1'b1;
        id_en_c       = 1'b1;
        bubble_c      = 1'b0;
        flush_c       = 1'b0;
        if (bus.mem_busy) begin
            if_en_c = 1'b0;
            id_en_c = 1'b0;
        end else if (bus.ex_redirect) begin
            flush_c       = 1'b1;
            bubble_c      = 1'b1;
            flush_cnt_nxt = FLUSH_INIT;
            state_nxt     = (FLUSH_INIT == 2'd0) ? RUN : FLUSH;
        end else if (state == FLUSH) begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
            if (flush_cnt <= 2'd1) begin
                flush_cnt_nxt = 2'd0;
                state_nxt     = RUN;
            end else begin
                flush_cnt_nxt = flush_cnt - 2'd1;
            end
        end else if (state == DRAIN || (bus.id_valid && bus.id_fence)) begin
            // the fence itself never enters EX; it retires as a bubble once the pipe is empty
            bubble_c = 1'b1;
            if (slots_empty) begin
                state_nxt = RUN;
            end else begin
                if_en_c   = 1'b0;
                id_en_c   = 1'b0;
                state_nxt = DRAIN;
            end
        end else if (load_use) begin
            if_en_c   = 1'b0;
            id_en_c   = 1'b0;
            bubble_c  = 1'b1;
            state_nxt = LDSTALL;
        end else begin
            state_nxt = RUN;
        end
    end

    // selects are relative to the slot positions after the edge: EX->MEM, MEM->WB
    assign enter_ex = bus.id_valid && !bubble_c;
    assign fwd1_d   = !enter_ex ? FWD_RF : (ex_hit1 && !ld_p0) ? FWD_MEM : mem_hit1 ? FWD_WB : FWD_RF;
    assign fwd2_d   = !enter_ex ? FWD_RF : (ex_hit2 && !ld_p0) ? FWD_MEM : mem_hit2 ? FWD_WB : FWD_RF;

    // ID -> EX(_p0) -> MEM(_p1) -> WB(_p2) slot tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            flush_cnt <= 2'd0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            fwd1_q    <= FWD_RF;
            fwd2_q    <= FWD_RF;
            stall_cnt <= '0;
        end else begin
            if (!if_en_c) stall_cnt <= sat_inc(stall_cnt);
            if (!bus.mem_busy) begin
                state     <= state_nxt;
                flush_cnt <= flush_cnt_nxt;
                vld_p0    <= enter_ex;
                vld_p1    <= vld_p0;
                vld_p2    <= vld_p1;
                fwd1_q    <= fwd1_d;
                fwd2_q    <= fwd2_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!bus.mem_busy) begin
            rd_p0 <= bus.id_rd;
            wb_p0 <= bus.id_wb;
            ld_p0 <= bus.id_load;
            rd_p1 <= rd_p0;
            wb_p1 <= wb_p0;
        end
    end

    assign bus.if_en        = rst_n & if_en_c;
    assign bus.id_en        = rst_n & id_en_c;
    assign bus.bubble       = ~rst_n | bubble_c;
    assign bus.flush        = rst_n & flush_c;
    assign bus.fwd_rs1      = fwd1_q;
    assign bus.fwd_rs2      = fwd2_q;
    assign bus.ctrl_state   = state;
    assign bus.stall_cycles = stall_cnt;
endmodule
